// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        RUN
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_WIDTH = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs an accepted byte stream MSB first into 32-bit words.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [31:0] next_word,
    output logic        word_ready
);

    logic [BYTE_IDX_WIDTH-1:0] byte_idx;
    logic [23:0]               partial;

    // Only three bytes ever need storing; the fourth completes the word on the fly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx <= '0;
            partial  <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            partial  <= '0;
        end else if (accept) begin
            byte_idx <= byte_idx + BYTE_IDX_WIDTH'(1);
            partial  <= {partial[15:0], data};
        end
    end

    assign next_word  = {partial, data};
    assign word_ready = accept && (byte_idx == BYTE_IDX_WIDTH'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory and holds the core in reset until done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int START_ADDR = 0,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);

    localparam int LEN_W = ADDR_WIDTH + 1;

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] word_idx;
    logic             pending;
    logic [LEN_W-1:0] pending_len;

    logic             start_req;
    logic [LEN_W-1:0] req_len;
    logic             out_of_range;
    logic             accept;
    logic             clear;
    logic [31:0]      next_word;
    logic             word_ready;

    // A request made while running is replayed from IDLE one cycle later.
    assign start_req    = (state == IDLE) && (load_start || pending);
    assign req_len      = pending ? pending_len : load_len;
    assign out_of_range = (START_ADDR + int'(req_len)) > (1 << ADDR_WIDTH);
    assign accept       = in_valid && (state == RECV);
    assign clear        = start_req && !out_of_range;
    assign in_ready     = (state == RECV);

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .accept     (accept),
        .data       (in_data),
        .next_word  (next_word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            core_hold   <= 1'b1;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            len         <= '0;
            word_idx    <= '0;
            pending     <= 1'b0;
            pending_len <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_req) begin
                        pending <= 1'b0;
                        if (out_of_range) begin
                            error <= 1'b1;
                        end else begin
                            error    <= 1'b0;
                            len      <= req_len;
                            word_idx <= '0;
                            if (req_len == '0) begin
                                state     <= RUN;
                                core_hold <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                state <= RECV;
                            end
                        end
                    end
                end
                RECV: begin
                    if (word_ready) begin
                        state      <= WRITE;
                        imem_we    <= 1'b1;
                        imem_addr  <= ADDR_WIDTH'(START_ADDR) + word_idx[ADDR_WIDTH-1:0];
                        imem_wdata <= DATA_WIDTH'(next_word);
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + LEN_W'(1);
                    if (word_idx + LEN_W'(1) == len) begin
                        state     <= RUN;
                        core_hold <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state <= RECV;
                    end
                end
                RUN: begin
                    if (load_start) begin
                        state       <= IDLE;
                        core_hold   <= 1'b1;
                        done        <= 1'b0;
                        pending     <= 1'b1;
                        pending_len <= load_len;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with a write-capturing memory model.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        load_start;
    logic [8:0]  load_len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;

    int          checks;
    int          errors;
    int          wrCount;
    int          baseCount;
    logic [7:0]  lastAddr;
    logic [31:0] mem [0:255];

    imem_loader #(
        .ADDR_WIDTH (8),
        .START_ADDR (0),
        .DATA_WIDTH (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every write strobe; a strobe held for two cycles counts twice.
    always @(negedge clk) begin
        if (reset && imem_we) begin
            mem[imem_addr] = imem_wdata;
            lastAddr       = imem_addr;
            wrCount        = wrCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic startLoad(input logic [8:0] len);
        load_len   = len;
        load_start = 1'b1;
        waitCycles(1);
        load_start = 1'b0;
    endtask

    // Present one byte and hold it until the loader has taken it.
    task automatic applyStimulus(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 100) begin
            waitCycles(1);
            n = n + 1;
        end
        checkOutput("in_ready_wait_timeout", 32'(n >= 100), 32'd0);
        waitCycles(1);
    endtask

    task automatic endStream();
        in_valid = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        wrCount    = 0;
        lastAddr   = '0;
        reset      = 1'b1;
        load_start = 1'b0;
        load_len   = '0;
        in_valid   = 1'b0;
        in_data    = '0;

        #2 reset = 1'b0;
        #1;
        checkOutput("reset_core_hold", 32'(core_hold), 32'd1);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_imem_we", 32'(imem_we), 32'd0);
        checkOutput("reset_imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("reset_imem_wdata", imem_wdata, 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_error", 32'(error), 32'd0);
        waitCycles(2);
        reset = 1'b1;
        waitCycles(1);

        $display("[TB] nominal load, len=2");
        startLoad(9'd2);
        checkOutput("nom_in_ready_recv", 32'(in_ready), 32'd1);
        checkOutput("nom_core_hold_recv", 32'(core_hold), 32'd1);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        applyStimulus(8'h56);
        applyStimulus(8'h78);
        applyStimulus(8'h9A);
        applyStimulus(8'hBC);
        applyStimulus(8'hDE);
        applyStimulus(8'hF0);
        endStream();
        waitCycles(1);
        checkOutput("nom_write_count", 32'(wrCount), 32'd2);
        checkOutput("nom_word0", mem[0], 32'h12345678);
        checkOutput("nom_word1", mem[1], 32'h9ABCDEF0);
        checkOutput("nom_core_hold", 32'(core_hold), 32'd0);
        checkOutput("nom_done", 32'(done), 32'd1);
        checkOutput("nom_in_ready_run", 32'(in_ready), 32'd0);

        $display("[TB] reload from RUN with gapped stream, len=1");
        baseCount = wrCount;
        startLoad(9'd1);
        checkOutput("reload_core_hold", 32'(core_hold), 32'd1);
        checkOutput("reload_done", 32'(done), 32'd0);
        applyStimulus(8'hAA);
        endStream();
        waitCycles(1);
        applyStimulus(8'hBB);
        endStream();
        waitCycles(1);
        applyStimulus(8'hCC);
        endStream();
        waitCycles(3);
        checkOutput("gap_no_early_write", 32'(wrCount), 32'(baseCount));
        applyStimulus(8'hDD);
        endStream();
        waitCycles(1);
        checkOutput("gap_write_count", 32'(wrCount), 32'(baseCount + 1));
        checkOutput("gap_word", mem[0], 32'hAABBCCDD);
        checkOutput("gap_addr", 32'(lastAddr), 32'd0);
        checkOutput("gap_core_hold", 32'(core_hold), 32'd0);
        checkOutput("gap_done", 32'(done), 32'd1);

        $display("[TB] zero-length load");
        baseCount = wrCount;
        startLoad(9'd0);
        waitCycles(1);
        checkOutput("zero_done", 32'(done), 32'd1);
        checkOutput("zero_core_hold", 32'(core_hold), 32'd0);
        waitCycles(3);
        checkOutput("zero_no_write", 32'(wrCount), 32'(baseCount));

        $display("[TB] out-of-range request, then full-depth load");
        startLoad(9'd257);
        waitCycles(1);
        checkOutput("range_error", 32'(error), 32'd1);
        checkOutput("range_core_hold", 32'(core_hold), 32'd1);
        checkOutput("range_done", 32'(done), 32'd0);
        waitCycles(3);
        checkOutput("range_in_ready_idle", 32'(in_ready), 32'd0);
        checkOutput("range_error_held", 32'(error), 32'd1);
        baseCount = wrCount;
        startLoad(9'd256);
        checkOutput("full_error_cleared", 32'(error), 32'd0);
        checkOutput("full_in_ready", 32'(in_ready), 32'd1);
        for (int w = 0; w < 256; w++) begin
            applyStimulus(8'(w));
            applyStimulus(~8'(w));
            applyStimulus(8'hA5);
            applyStimulus(8'(w));
        end
        endStream();
        waitCycles(1);
        checkOutput("full_write_count", 32'(wrCount), 32'(baseCount + 256));
        checkOutput("full_last_addr", 32'(lastAddr), 32'd255);
        checkOutput("full_word255", mem[255], 32'hFF00A5FF);
        checkOutput("full_word0", mem[0], 32'h00FFA500);
        checkOutput("full_word100", mem[100], 32'h649BA564);
        checkOutput("full_done", 32'(done), 32'd1);

        $display("[TB] asynchronous reset mid-word");
        startLoad(9'd2);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        endStream();
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_core_hold", 32'(core_hold), 32'd1);
        checkOutput("arst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("arst_imem_we", 32'(imem_we), 32'd0);
        checkOutput("arst_imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("arst_imem_wdata", imem_wdata, 32'd0);
        checkOutput("arst_done", 32'(done), 32'd0);
        checkOutput("arst_error", 32'(error), 32'd0);
        waitCycles(2);
        reset = 1'b1;
        waitCycles(1);
        baseCount = wrCount;
        startLoad(9'd1);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        endStream();
        waitCycles(1);
        checkOutput("post_rst_write_count", 32'(wrCount), 32'(baseCount + 1));
        checkOutput("post_rst_word", mem[0], 32'h11223344);
        checkOutput("post_rst_addr", 32'(lastAddr), 32'd0);
        checkOutput("post_rst_done", 32'(done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader upstream of the single-cycle core and its instruction memory. It receives a byte stream over a valid/ready handshake and packs each four bytes into a 32-bit word, MSB first. It writes the words into instruction memory at consecutive addresses, holding the core in reset until the load completes. On completion it releases the core to run. A new load can be requested at any time, which puts the core back into reset.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width (depth = 2^ADDR_WIDTH words)
START_ADDR, 0, first word address written
DATA_WIDTH, 32, instruction word width (fixed at 32; 4 bytes per word)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
load_start  in  1  one-cycle pulse requesting a new load
load_len  in  ADDR_WIDTH+1  number of words to load; sampled on load_start
in_valid  in  1  byte-stream valid
in_data  in  8  byte-stream data
in_ready  out  1  loader can accept a byte
imem_we  out  1  instruction-memory write enable
imem_addr  out  ADDR_WIDTH  instruction-memory word address
imem_wdata  out  32  instruction-memory write data
core_hold  out  1  active-high; holds the core in reset while 1
done  out  1  load finished and core released
error  out  1  last load request was rejected (out of range)

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE.
  - core_hold=1.
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - done=0, error=0.
  - Byte count=0, word count=0.
- States:
  - IDLE: core_hold=1, in_ready=0.
    - load_start with START_ADDR+load_len > 2^ADDR_WIDTH: error=1, stay in IDLE.
    - load_start with load_len=0: error=0, go to RUN next cycle; no writes.
    - Otherwise: latch len, clear counters, error=0, go to RECV.
  - RECV: in_ready=1.
    - A byte is accepted on a cycle with in_valid and in_ready both 1.
    - Packing: word = {word[23:0], in_data}. Byte 0 lands in bits [31:24].
    - On accepting the 4th byte, go to WRITE the next cycle.
  - WRITE: exactly one cycle.
    - imem_we=1, imem_addr=START_ADDR+word_idx, imem_wdata=packed word, in_ready=0.
    - word_idx increments.
    - If word_idx+1 == len, go to RUN; otherwise go to RECV.
  - RUN: core_hold=0, done=1, in_ready=0. Incoming bytes are ignored.
    - load_start: core_hold=1 and done=0 on the next cycle, then handled exactly as in IDLE (range check included).
- Latency: the write strobe comes one cycle after the 4th byte is accepted. Peak throughput is 4 bytes per 5 cycles.
- imem_we is high only in WRITE. imem_addr and imem_wdata hold their last values otherwise.
- Boundaries and simultaneous events:
  - load_start during RECV or WRITE is ignored. The current load runs to completion.
  - in_valid dropping mid-word retains the partial word with no timeout.
  - The last word may be written at address 2^ADDR_WIDTH-1; addresses never wrap.
  - Asserting reset mid-load aborts immediately. Partial memory contents are left as-is and core_hold=1.
- All outputs are registered. No combinational path from inputs to outputs except in_ready, which depends only on state.

Decomposition:
- Package imem_loader_pkg:
  - State enum {IDLE, RECV, WRITE, RUN}.
  - BYTES_PER_WORD=4.
  - Byte-index width constant (2).
- One sub-module, byte_packer:
  - 8-to-32 shift register with a 2-bit byte counter.
  - Emits word_ready on the 4th accepted byte.
  - Has a clear input.

Test Plan:
- Nominal load: reset released, load_start with len=2; bytes 12 34 56 78 9A BC DE F0 sent with in_valid held high -> two write cycles: addr0=0x12345678, addr1=0x9ABCDEF0. Then core_hold=0, done=1.
- Gapped stream: len=1 with in_valid toggling every other cycle, bytes AA BB CC DD -> single write 0xAABBCCDD at START_ADDR. No write occurs before the 4th byte.
- Zero length: load_start with len=0 -> no imem_we. done=1 and core_hold=0 within 2 cycles.
- Range error: ADDR_WIDTH=8, START_ADDR=0, len=257 -> error=1, state stays IDLE, core_hold=1, in_ready=0. A following len=256 is accepted and error clears; last write at addr 255.
- Reload from RUN: after a completed load, pulse load_start with len=1 -> core_hold=1 and done=0 the next cycle; the new word is written at START_ADDR, then the core is released again.
- Async reset mid-load: drop reset after 2 bytes of a word -> all outputs go to reset values immediately, without waiting for a clock edge. After reset is released, a fresh len=1 load packs only the new bytes.
